fuse_responder: RTL and testbench
=================================

FUSE_RESPONDER -- requirements
Module: fuse_responder

Interface
REQ-001 SHALL have parameter FUSE_MEM_SIZE, default 34, number of 32-bit fuse words.
REQ-002 SHALL have parameter READ_LATENCY, default 2, cycles spent in BUSY, legal range 1..15.
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fuse_req_i  input  1  level read request from the key-transfer wrapper.
REQ-006 SHALL have port fuse_addr_i  input  32  fuse word index.
REQ-007 SHALL have port fuse_rdata_o  output  32  read data.
REQ-008 SHALL have port fuse_valid_o  output  1  fuse_rdata_o/fuse_err_o valid.
REQ-009 SHALL have port fuse_err_o  output  1  out-of-range read.
REQ-010 SHALL have port prog_we_i  input  1  one-cycle program strobe.
REQ-011 SHALL have port prog_addr_i  input  32  program word index.
REQ-012 SHALL have port prog_wdata_i  input  32  bits to blow.
REQ-013 SHALL have port lock_i  input  1  programming lock request.
REQ-014 SHALL have port locked_o  output  1  sticky programming lock status.
REQ-015 SHALL have port rd_count_o  output  16  completed-read count (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-017 SHALL, in IDLE with fuse_req_i=1, capture fuse_addr_i and enter BUSY next cycle.
REQ-018 SHALL stay in BUSY exactly READ_LATENCY cycles via down-counter, then enter DONE.
REQ-019 SHALL sample storage on the BUSY->DONE edge; fuse_valid_o=1 from first DONE cycle onward, so valid rises READ_LATENCY+1 cycles after the req sample edge.
REQ-020 SHALL hold fuse_rdata_o, fuse_err_o, fuse_valid_o stable in DONE while fuse_req_i=1.
REQ-021 SHALL, in DONE with fuse_req_i=0, return to IDLE and drop fuse_valid_o next cycle; fuse_rdata_o and fuse_err_o return to 0 the same cycle.
REQ-022 SHALL ignore fuse_addr_i changes outside IDLE; a new read requires req low for at least one cycle.
REQ-023 SHALL abort a read if fuse_req_i drops in BUSY: return to IDLE next cycle, no valid pulse, no count.
REQ-024 SHALL, for captured addr >= FUSE_MEM_SIZE, return rdata=0 and fuse_err_o=1 with normal latency.
REQ-025 SHALL apply prog_we_i as OTP: word <= word | prog_wdata_i, only when prog_addr_i < FUSE_MEM_SIZE and locked_o=0; bits never clear.
REQ-026 SHALL silently drop out-of-range or locked program strobes.
REQ-027 SHALL make a program write visible the cycle after the strobe; a write in the same cycle as the BUSY->DONE sample returns the old value.
REQ-028 SHALL set locked_o the cycle after lock_i=1 and keep it set until reset; lock_i and prog_we_i in the same cycle: write still applies.
REQ-029 SHALL serve reads at any lock state.

Reset
REQ-030 SHALL on rst_i=1 force state IDLE, counter 0, fuse_rdata_o=0, fuse_valid_o=0, fuse_err_o=0, locked_o=0, rd_count_o=0, all fuse words 0 (unblown).
REQ-031 SHALL, when reset asserts mid-read or mid-program, discard the operation; first post-reset cycle is IDLE.

Configuration
REQ-032 SHALL, with FUSE_RD_CNT_EN defined, increment rd_count_o by 1 on each IDLE... BUSY->DONE transition (including err reads), saturating at 16'hFFFF.
REQ-033 SHALL, without FUSE_RD_CNT_EN, tie rd_count_o to 0 and instantiate no counter register.

Verification
REQ-034 Program addr 3 = 32'hA5A5_0000, then 32'h0000_5A5A; read addr 3 with READ_LATENCY=2 -> valid 3 cycles after req sample edge, rdata=32'hA5A5_5A5A, err=0.
REQ-035 Read addr 34 (and 32'hFFFF_FFFF) -> valid after latency, rdata=0, err=1; rd_count_o increments when FUSE_RD_CNT_EN defined.
REQ-036 Assert lock_i, then program addr 5 = 32'hFFFF_FFFF -> locked_o=1, read addr 5 returns 0.
REQ-037 Drop fuse_req_i during BUSY -> no valid pulse, FSM IDLE next cycle, rd_count_o unchanged; change fuse_addr_i in DONE -> rdata unchanged.
REQ-038 Program addr 7 on the exact BUSY->DONE cycle of a read of addr 7 -> that read returns old value; next read returns new value.
REQ-039 Assert rst_i during BUSY after programming addr 1 -> all outputs 0, locked_o=0, read addr 1 returns 0.

Source files
------------

// File: rtl/fuse_responder_if.sv
// Fuse read/program bus between the key-transfer wrapper and fuse_responder.
// Read: fuse_req_i/fuse_addr_i in; fuse_rdata_o/fuse_valid_o/fuse_err_o out.
// Program: prog_we_i/prog_addr_i/prog_wdata_i in.
interface fuse_responder_if;
    logic        fuse_req_i;
    logic [31:0] fuse_addr_i;
    logic [31:0] fuse_rdata_o;
    logic        fuse_valid_o;
    logic        fuse_err_o;
    logic        prog_we_i;
    logic [31:0] prog_addr_i;
    logic [31:0] prog_wdata_i;

    modport master (
        output fuse_req_i, fuse_addr_i,
        output prog_we_i, prog_addr_i, prog_wdata_i,
        input  fuse_rdata_o, fuse_valid_o, fuse_err_o
    );

    modport slave (
        input  fuse_req_i, fuse_addr_i,
        input  prog_we_i, prog_addr_i, prog_wdata_i,
        output fuse_rdata_o, fuse_valid_o, fuse_err_o
    );
endinterface

// File: rtl/fuse_responder.sv
// OTP fuse array model with a level-request read FSM and sticky program lock.
// Ports: clk_i, rst_i (sync, active-high), bus (fuse_responder_if.slave),
//   lock_i, locked_o (sticky lock), rd_count_o (completed reads).
// Option: define FUSE_RD_CNT_EN to build the saturating read counter;
//   otherwise rd_count_o is tied to 0.
module fuse_responder #(
    parameter int FUSE_MEM_SIZE = 34,
    parameter int READ_LATENCY  = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    fuse_responder_if.slave    bus,
    input  logic               lock_i,
    output logic               locked_o,
    output logic [15:0]        rd_count_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int AW = (FUSE_MEM_SIZE > 1) ? $clog2(FUSE_MEM_SIZE) : 1;

    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        valid_q;
    logic        locked_q;
    logic [31:0] mem_q [FUSE_MEM_SIZE];

    logic        prog_ok;
    logic        rd_hit;

    assign prog_ok = bus.prog_we_i && !locked_q &&
                     (bus.prog_addr_i < 32'(FUSE_MEM_SIZE));
    assign rd_hit  = addr_q < 32'(FUSE_MEM_SIZE);

    assign bus.fuse_rdata_o = rdata_q;
    assign bus.fuse_err_o   = err_q;
    assign bus.fuse_valid_o = valid_q;
    assign locked_o         = locked_q;

    // The counter is loaded with READ_LATENCY and the sample happens on the
    // edge where it is already zero, so valid rises READ_LATENCY+1 edges
    // after the edge that saw the request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.fuse_req_i) begin
                        addr_q  <= bus.fuse_addr_i;
                        cnt_q   <= 4'(READ_LATENCY);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!bus.fuse_req_i) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        rdata_q <= rd_hit ? mem_q[addr_q[AW-1:0]] : 32'h0;
                        err_q   <= !rd_hit;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (!bus.fuse_req_i) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bits can only be blown; the lock gate uses the registered lock so a
    // strobe coincident with lock_i still lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < FUSE_MEM_SIZE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (prog_ok) begin
            mem_q[bus.prog_addr_i[AW-1:0]] <=
                mem_q[bus.prog_addr_i[AW-1:0]] | bus.prog_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q <= 1'b0;
        end else begin
            locked_q <= locked_q | lock_i;
        end
    end

`ifdef FUSE_RD_CNT_EN
    logic [15:0] rd_cnt_q;
    logic        sample;

    assign sample = (state_q == BUSY) && bus.fuse_req_i && (cnt_q == 4'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= '0;
        end else if (sample && (rd_cnt_q != 16'hFFFF)) begin
            rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign rd_count_o = rd_cnt_q;
`else
    assign rd_count_o = '0;
`endif
endmodule

// File: tb/tb_fuse_responder.sv
// Self-checking bench for fuse_responder: scoreboard of expected read
// results against a behavioural fuse model.
module tb_fuse_responder;
    localparam int MEM = 34;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lock = 1'b0;
    logic        locked;
    logic [15:0] rd_count;

    fuse_responder_if bus ();

    fuse_responder #(
        .FUSE_MEM_SIZE (MEM),
        .READ_LATENCY  (LAT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus.slave),
        .lock_i     (lock),
        .locked_o   (locked),
        .rd_count_o (rd_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mdl [MEM];
    bit          mlock;
    int          mcnt;
    logic [32:0] sb_q [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt();
`ifdef FUSE_RD_CNT_EN
        return (mcnt > 65535) ? 16'hFFFF : 16'(mcnt);
`else
        return 16'h0;
`endif
    endfunction

    function automatic logic [32:0] exp_rd(input logic [31:0] a);
        if (a < MEM) return {1'b0, mdl[a]};
        return {1'b1, 32'h0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MEM; i++) mdl[i] = '0;
        mlock = 1'b0;
        mcnt = 0;
        sb_q.delete();
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        bus.prog_we_i    = 1'b1;
        bus.prog_addr_i  = a;
        bus.prog_wdata_i = d;
        @(negedge clk);
        bus.prog_we_i = 1'b0;
        if (a < MEM && !mlock) mdl[a] = mdl[a] | d;
    endtask

    // Edge count includes the request sample edge, so valid is seen on
    // the LAT+2'th falling edge after the request is driven.
    task automatic do_read(input logic [31:0] a, input string tag);
        int n;
        logic [32:0] e;
        sb_q.push_back(exp_rd(a));
        bus.fuse_addr_i = a;
        bus.fuse_req_i  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.fuse_valid_o && n < 20);
        chk({tag, "_lat"}, 64'(n), 64'(LAT + 2));
        mcnt++;
        e = sb_q.pop_front();
        chk({tag, "_data"}, {31'h0, bus.fuse_err_o, bus.fuse_rdata_o},
            {31'h0, e});
        chk({tag, "_cnt"}, 64'(rd_count), 64'(exp_cnt()));
        bus.fuse_addr_i = ~a;
        @(negedge clk);
        chk({tag, "_hold"},
            {30'h0, bus.fuse_valid_o, bus.fuse_err_o, bus.fuse_rdata_o},
            {30'h0, 1'b1, e});
        bus.fuse_req_i = 1'b0;
        @(negedge clk);
        chk({tag, "_drop"},
            {30'h0, bus.fuse_valid_o, bus.fuse_err_o, bus.fuse_rdata_o},
            64'h0);
    endtask

    initial begin
        logic [32:0] e;
        int c0;
        bus.fuse_req_i   = 1'b0;
        bus.fuse_addr_i  = '0;
        bus.prog_we_i    = 1'b0;
        bus.prog_addr_i  = '0;
        bus.prog_wdata_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out",
            {bus.fuse_valid_o, bus.fuse_err_o, bus.fuse_rdata_o}, 64'h0);
        chk("rst_lock", 64'(locked), 64'h0);
        chk("rst_cnt", 64'(rd_count), 64'h0);

        prog(32'd3, 32'hA5A5_0000);
        prog(32'd3, 32'h0000_5A5A);
        do_read(32'd3, "rd3");
        chk("rd3_or", 64'(mdl[3]), 64'hA5A5_5A5A);

        prog(32'd33, 32'hDEAD_BEEF);
        prog(32'd34, 32'hFFFF_FFFF);
        do_read(32'd33, "rd33");
        do_read(32'd34, "rd34");
        do_read(32'hFFFF_FFFF, "rdmax");
        do_read(32'd0, "rd0");

        c0 = mcnt;
        bus.fuse_addr_i = 32'd3;
        bus.fuse_req_i  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.fuse_req_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_valid", 64'(bus.fuse_valid_o), 64'h0);
        end
        chk("abort_cnt", 64'(mcnt), 64'(c0));
        chk("abort_rdcnt", 64'(rd_count), 64'(exp_cnt()));
        do_read(32'd3, "post_abort");

        prog(32'd7, 32'h0000_00F0);
        e = exp_rd(32'd7);
        sb_q.push_back(e);
        bus.fuse_addr_i = 32'd7;
        bus.fuse_req_i  = 1'b1;
        repeat (3) @(negedge clk);
        bus.prog_we_i    = 1'b1;
        bus.prog_addr_i  = 32'd7;
        bus.prog_wdata_i = 32'h0F00_0000;
        @(negedge clk);
        bus.prog_we_i = 1'b0;
        mdl[7] = mdl[7] | 32'h0F00_0000;
        mcnt++;
        e = sb_q.pop_front();
        chk("race_valid", 64'(bus.fuse_valid_o), 64'h1);
        chk("race_old", {31'h0, bus.fuse_err_o, bus.fuse_rdata_o},
            {31'h0, e});
        bus.fuse_req_i = 1'b0;
        @(negedge clk);
        do_read(32'd7, "race_new");

        prog(32'd1, 32'h1234_5678);
        bus.fuse_addr_i = 32'd1;
        bus.fuse_req_i  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.fuse_req_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("mrst_out",
            {bus.fuse_valid_o, bus.fuse_err_o, bus.fuse_rdata_o}, 64'h0);
        chk("mrst_lock", 64'(locked), 64'h0);
        chk("mrst_cnt", 64'(rd_count), 64'h0);
        do_read(32'd1, "mrst_rd1");

        lock = 1'b1;
        bus.prog_we_i    = 1'b1;
        bus.prog_addr_i  = 32'd9;
        bus.prog_wdata_i = 32'h0000_0055;
        @(negedge clk);
        lock = 1'b0;
        bus.prog_we_i = 1'b0;
        mdl[9] = mdl[9] | 32'h0000_0055;
        mlock = 1'b1;
        chk("lock_set", 64'(locked), 64'h1);
        prog(32'd5, 32'hFFFF_FFFF);
        prog(32'd9, 32'hFF00_0000);
        do_read(32'd5, "lock_rd5");
        do_read(32'd9, "lock_rd9");
        chk("lock_hold", 64'(locked), 64'h1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("unlock", 64'(locked), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
